// File: rtl/calculator_arbiter.sv
// calculator_arbiter: round-robin sharing of one calculator among NUM_REQ
// requesters. req_* in, rsp_* out (valid/ready), calc_* drive the calculator.
module calculator_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CALC_LATENCY = 2,
  localparam int IW          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [2*NUM_REQ-1:0] req_fn,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [15:0]          rsp_data,
  output logic [7:0]           calc_a,
  output logic [7:0]           calc_b,
  output logic [1:0]           calc_fn,
  input  logic [15:0]          calc_out,
  output logic                 busy,
  output logic [IW-1:0]        grant_id
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      gid_q, gid_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [7:0]         a_q, a_d;
  logic [7:0]         b_q, b_d;
  logic [1:0]         fn_q, fn_d;
  logic [15:0]        rsp_q, rsp_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      win;
  logic [IW-1:0]      cand;
  logic               hit;
  logic [7:0]         sel_a, sel_b;
  logic [1:0]         sel_fn;

  // Scan upward from the pointer with wrap; first valid requester wins.
  always_comb begin
    gnt  = '0;
    win  = '0;
    cand = '0;
    hit  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!hit && req_valid[cand]) begin
        hit = 1'b1;
        win = cand;
      end
    end
    if (hit) gnt[win] = 1'b1;
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_fn = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a  = req_a[8*i +: 8];
        sel_b  = req_b[8*i +: 8];
        sel_fn = req_fn[2*i +: 2];
      end
    end
  end

  // Gated by rst so grants never appear while reset is held.
  assign req_ready = (state_q == S_IDLE && !rst) ? gnt : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    fn_d    = fn_q;
    rsp_d   = rsp_q;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          a_d     = sel_a;
          b_d     = sel_b;
          fn_d    = sel_fn;
          gid_d   = win;
          cnt_d   = 4'(CALC_LATENCY);
          ptr_d   = (win == IW'(NUM_REQ-1)) ? '0 : win + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt_q == 4'd0) begin
          rsp_d   = calc_out;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready[gid_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fn_q    <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fn_q    <= fn_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    rsp_valid        = '0;
    rsp_valid[gid_q] = (state_q == S_RESP);
  end

  assign rsp_data = rsp_q;
  assign calc_a   = a_q;
  assign calc_b   = b_q;
  assign calc_fn  = fn_q;
  assign busy     = (state_q != S_IDLE);
  assign grant_id = gid_q;

endmodule

// File: doc/calculator_arbiter.md
# calculator_arbiter

Round-robin arbiter and sequencer that shares one calculator datapath (8-bit operands A/B, 2-bit function select, 16-bit result) among NUM_REQ requesters. Each requester submits an operation through a valid/ready handshake. The arbiter drives the calculator's operand and function inputs, waits a fixed number of cycles for the result, and returns it to the granted requester through a valid/ready response handshake. It sits between the client blocks and the single calculator instance, and is the only driver of the calculator inputs.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- CALC_LATENCY, 2: cycles from operands stable on calc_* to a valid calc_out; legal range 0..15 (0 = combinational calculator).
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  one-hot grant/accept, or all-zero.
- req_a  in  8*NUM_REQ  operand A; requester i owns bits [8i+7:8i].
- req_b  in  8*NUM_REQ  operand B, packed the same way as req_a.
- req_fn  in  2*NUM_REQ  function select; requester i owns bits [2i+1:2i].
- rsp_valid  out  NUM_REQ  one-hot: result available for requester i.
- rsp_ready  in  NUM_REQ  requester i accepts its result.
- rsp_data  out  16  result; shared by all requesters, qualified by rsp_valid.
- calc_a  out  8  operand A to the calculator.
- calc_b  out  8  operand B to the calculator.
- calc_fn  out  2  function select to the calculator.
- calc_out  in  16  calculator result.
- busy  out  1  high while state is not IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or most recent grant.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - ISSUE: operands held on calc_*, latency counter running.
  - RESP: rsp_valid held until the response handshake.
- IDLE: req_ready is combinational from req_valid and the round-robin pointer. It is one-hot on the first valid requester at or after the pointer, scanning upward with wrap.
  - Handshake (req_valid[i] & req_ready[i]) in IDLE:
    - registers req_a/b/fn of requester i into calc_a/b/fn;
    - sets grant_id=i;
    - loads the counter with CALC_LATENCY;
    - moves to ISSUE;
    - sets pointer = (i+1) mod NUM_REQ.
- req_ready is 0 in ISSUE and RESP. At most one bit is ever set.
- ISSUE: if counter==0, capture calc_out into rsp_data and go to RESP; otherwise decrement the counter.
- RESP: rsp_valid[grant_id]=1. The handshake with rsp_ready[grant_id] returns the FSM to IDLE. rsp_ready of other requesters is ignored.
- calc_a/b/fn change only on a request handshake. They stay stable through ISSUE, RESP and the following IDLE.
- The arbiter does not interpret function codes; results pass through unchanged, all 16 bits.
- Requesters must hold req_valid and operands stable until req_ready. Dropping req_valid before the grant is legal and leaves no state behind.

## Timing
- Reset (asynchronous assert; release sampled on clk):
  - state IDLE, pointer 0, counter 0;
  - rsp_valid=0, rsp_data=0, calc_a=0, calc_b=0, calc_fn=0, grant_id=0, busy=0;
  - req_ready=0 while rst is high.
- Request handshake at cycle T:
  - calc_* valid from T+1;
  - calc_out sampled at the end of cycle T+1+CALC_LATENCY;
  - rsp_valid high from T+2+CALC_LATENCY.
- Response handshake at cycle R: state is IDLE at R+1, and the next grant can occur at R+1.
  - Minimum issue interval is CALC_LATENCY+3 cycles.
- rsp_valid and rsp_data hold indefinitely under backpressure, and no new request is accepted during that time.
- Reset asserted during ISSUE or RESP: the operation is dropped, no rsp_valid is produced, and the pointer returns to 0.
- Simultaneous requests are resolved purely by the pointer. A requester holding req_valid waits at most NUM_REQ-1 other grants.

## Test plan
Bench calculator model: fn 00 = add, 10 = mul, registered with the same latency as CALC_LATENCY.
- Reset check: assert rst mid-cycle with all req_valid high -> all outputs 0 asynchronously; after release the first grant goes to requester 0.
- Single request, CALC_LATENCY=2: requester 2 sends a=3, b=4, fn=00 with handshake at T -> calc_a=3 and calc_b=4 at T+1; rsp_valid=4'b0100 and rsp_data=7 at T+4; grant_id=2.
- All four requesters valid after reset, each with rsp_ready tied high, using mul a=255, b=255 -> grants in order 0,1,2,3,0; every rsp_data=65025; issue interval is exactly 5 cycles.
- Backpressure: rsp_ready low for 6 cycles while other requesters are valid -> rsp_valid and rsp_data stable, req_ready all 0, busy=1; the grant resumes the cycle after the handshake.
- Fairness: requesters 1 and 3 continuously valid -> grant sequence 1,3,1,3; requester 0 raised mid-stream is served within 2 grants.
- Reset during ISSUE, and a CALC_LATENCY=0 build: reset mid-ISSUE -> no rsp_valid, pointer back to 0. With CALC_LATENCY=0, a request at T gives rsp_valid at T+2 with the correct sum.
